// File: rtl/lm_sm_sequencer_pkg.sv
// rtl/lm_sm_sequencer_pkg.sv - shared state encoding and default sizes for the LM/SM sequencer
package lm_sm_sequencer_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int NREGS_DEF  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index width for an n-entry register list; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// rtl/lm_sm_sequencer_if.sv - command, register-file and data-memory signals of the LM/SM sequencer
interface lm_sm_sequencer_if
    import lm_sm_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF
);
    localparam int IDX_W = idx_w(NREGS);

    logic              start;
    logic              is_store;
    logic [ADDR_W-1:0] base_addr;
    logic [NREGS-1:0]  reg_list;
    logic              hold;
    logic [DATA_W-1:0] rf_rdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              stall_req;
    logic              done;
    logic [IDX_W-1:0]  reg_idx;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write_n;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    // The sequencer itself.
    modport master (
        input  start, is_store, base_addr, reg_list, hold, rf_rdata, mem_rdata,
        output busy, stall_req, done, reg_idx, mem_addr, mem_wdata,
        output mem_write_n, rf_we, rf_wdata
    );

    // Pipeline, register file and data memory around it.
    modport slave (
        output start, is_store, base_addr, reg_list, hold, rf_rdata, mem_rdata,
        input  busy, stall_req, done, reg_idx, mem_addr, mem_wdata,
        input  mem_write_n, rf_we, rf_wdata
    );

endinterface

// File: rtl/lm_sm_sequencer_lsb_priority_enc.sv
// rtl/lm_sm_sequencer_lsb_priority_enc.sv - combinational index of the lowest set bit, with valid flag
module lsb_priority_enc
    import lm_sm_sequencer_pkg::*;
#(
    parameter int N = NREGS_DEF
) (
    input  logic [N-1:0]         vec,
    output logic [idx_w(N)-1:0]  idx,
    output logic                 valid
);
    localparam int W = idx_w(N);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        valid = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - walks an LM/SM register list and issues one data-memory access per set bit
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    lm_sm_sequencer_if.master bus
);
    localparam int IDX_W = idx_w(NREGS);

    state_t            state;
    logic [NREGS-1:0]  list_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] offset_q;
    logic              store_q;
    logic              busy_q;
    logic              done_q;

    logic [IDX_W-1:0]  cur_idx;
    logic              cur_valid;
    logic [NREGS-1:0]  list_next;
    logic              step;

    lsb_priority_enc #(.N(NREGS)) u_enc (
        .vec   (list_q),
        .idx   (cur_idx),
        .valid (cur_valid)
    );

    always_comb begin
        list_next = list_q & ~(NREGS'(1) << cur_idx);
    end

    // A transfer happens this cycle only when not frozen and not being reset.
    assign step = (state == S_XFER) && cur_valid && !bus.hold && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            list_q   <= '0;
            base_q   <= '0;
            offset_q <= '0;
            store_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        base_q   <= bus.base_addr;
                        list_q   <= bus.reg_list;
                        store_q  <= bus.is_store;
                        offset_q <= '0;
                        busy_q   <= 1'b1;
                        if (bus.reg_list == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= S_XFER;
                        end
                    end
                end
                S_XFER: begin
                    if (!bus.hold) begin
                        list_q   <= list_next;
                        offset_q <= offset_q + ADDR_W'(1);
                        if (list_next == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.stall_req   = busy_q || ((state == S_IDLE) && bus.start && !reset);
    assign bus.reg_idx     = cur_idx;
    assign bus.mem_addr    = base_q + offset_q;
    assign bus.mem_write_n = !(step && store_q);
    assign bus.rf_we       = step && !store_q;
    assign bus.mem_wdata   = bus.rf_rdata;
    assign bus.rf_wdata    = bus.mem_rdata;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb/tb_lm_sm_sequencer.sv - self-checking bench for lm_sm_sequencer with memory/regfile models
module tb_lm_sm_sequencer;
    import lm_sm_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lm_sm_sequencer_if bus ();

    lm_sm_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] dmem [0:65535];
    logic [15:0] rf   [8];

    assign bus.mem_rdata = dmem[bus.mem_addr];
    assign bus.rf_rdata  = rf[bus.reg_idx];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_store;
        logic [15:0] base;
        logic [7:0]  list;
        logic        hold_first;
        int          xfers;
        int          done_cyc;
        int          busy_cyc;
        logic [15:0] first_addr;
        logic [15:0] last_addr;
        int          last_idx;
    } vec_t;

    task automatic idle_outputs(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_stall"}, 32'(bus.stall_req), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_wn"},    32'(bus.mem_write_n), 32'd1);
        check({tag, "_rfwe"},  32'(bus.rf_we), 32'd0);
    endtask

    // Expected behaviour: a queue of (index, address) transfers in ascending
    // register order, one consumed per un-held cycle, then a single done cycle.
    task automatic run_op(input logic st, input logic [15:0] base, input logic [7:0] list,
                          input int hold_mode, input logic noise,
                          output int n_x, output int d_cyc, output int b_cyc,
                          output logic [15:0] a_first, output logic [15:0] a_last,
                          output int i_last);
        logic [15:0] rf0 [8];
        logic [15:0] exp_rf [8];
        logic [15:0] exp_val [$];
        int          q_idx [$];
        logic [15:0] q_addr [$];
        logic [15:0] chk_addr [$];
        int          k;
        int          holds;
        bit          fin;
        logic        h;
        logic        exp_wn;
        logic        exp_rfwe;

        n_x = 0; d_cyc = 0; b_cyc = 0; a_first = '0; a_last = '0; i_last = 0;
        holds = 0; fin = 0; k = 0;
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        rf0 = rf;
        exp_rf = rf;
        for (int j = 0; j < 8; j++) begin
            if (list[j]) begin
                q_idx.push_back(j);
                q_addr.push_back(base + 16'(k));
                exp_val.push_back(rf0[j]);
                if (!st) exp_rf[j] = dmem[base + 16'(k)];
                k++;
            end
        end
        chk_addr = q_addr;

        @(negedge clk);
        bus.start = 1'b1; bus.is_store = st; bus.base_addr = base; bus.reg_list = list; bus.hold = 1'b0;
        #1;
        check("start_stall", 32'(bus.stall_req), 32'd1);
        check("start_busy",  32'(bus.busy), 32'd0);

        for (int c = 1; c <= 40 && !fin; c++) begin
            @(negedge clk);
            bus.start = noise;
            if (noise) begin
                bus.is_store  = 1'($urandom);
                bus.base_addr = 16'($urandom);
                bus.reg_list  = 8'($urandom);
            end
            h = 1'b0;
            if (hold_mode == 1) h = (c == 1);
            else if (hold_mode == 2 && holds < 6) h = ($urandom_range(3) == 0);
            bus.hold = h;
            #1;
            if (q_idx.size() != 0) begin
                check("xfer_busy", 32'(bus.busy), 32'd1);
                check("xfer_done", 32'(bus.done), 32'd0);
                check("reg_idx",   32'(bus.reg_idx), 32'(q_idx[0]));
                check("mem_addr",  32'(bus.mem_addr), 32'(q_addr[0]));
                exp_wn   = !(st && !h);
                exp_rfwe = !st && !h;
                if (h) holds++;
                else begin
                    void'(q_idx.pop_front());
                    void'(q_addr.pop_front());
                end
            end else begin
                check("done_busy", 32'(bus.busy), 32'd1);
                check("done_pulse", 32'(bus.done), 32'd1);
                exp_wn = 1'b1;
                exp_rfwe = 1'b0;
                fin = 1;
            end
            check("mem_write_n", 32'(bus.mem_write_n), 32'(exp_wn));
            check("rf_we",       32'(bus.rf_we), 32'(exp_rfwe));
            check("stall_req",   32'(bus.stall_req), 32'd1);

            if (!bus.mem_write_n || bus.rf_we) begin
                if (n_x == 0) a_first = bus.mem_addr;
                a_last = bus.mem_addr;
                i_last = int'(bus.reg_idx);
                n_x++;
                if (!bus.mem_write_n) dmem[bus.mem_addr] = bus.mem_wdata;
                if (bus.rf_we) rf[bus.reg_idx] = bus.rf_wdata;
            end
            if (bus.busy) b_cyc++;
            if (bus.done && d_cyc == 0) d_cyc = c;
        end

        @(negedge clk);
        bus.start = 1'b0; bus.hold = 1'b0;
        #1;
        idle_outputs("after");
        if (bus.busy) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end

        if (st) begin
            for (int i = 0; i < chk_addr.size(); i++)
                check("sm_mem", 32'(dmem[chk_addr[i]]), 32'(exp_val[i]));
        end else begin
            for (int j = 0; j < 8; j++)
                check("lm_rf", 32'(rf[j]), 32'(exp_rf[j]));
        end
    endtask

    initial begin
        vec_t        vt [6];
        int          n_x, d_cyc, b_cyc, i_last, dn_seen;
        logic [15:0] a_first, a_last;
        logic        st;
        logic [15:0] base;
        logic [7:0]  list;
        int          r;

        for (int a = 0; a < 65536; a++) dmem[a] = 16'(a * 40503) ^ 16'h5A5A;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0;
        bus.start = 1'b0; bus.is_store = 1'b0; bus.base_addr = '0; bus.reg_list = '0; bus.hold = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        idle_outputs("reset");
        check("reset_reg_idx",  32'(bus.reg_idx), 32'd0);
        check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);

        vt[0] = '{1'b1, 16'h0010, 8'b1010_0101, 1'b0, 4, 5, 5, 16'h0010, 16'h0013, 7};
        vt[1] = '{1'b0, 16'h0000, 8'b0000_1100, 1'b0, 2, 3, 3, 16'h0000, 16'h0001, 3};
        vt[2] = '{1'b0, 16'h0ABC, 8'b0000_0000, 1'b0, 0, 1, 1, 16'h0000, 16'h0000, 0};
        vt[3] = '{1'b1, 16'hFFFF, 8'b0000_0011, 1'b1, 2, 4, 4, 16'hFFFF, 16'h0000, 1};
        vt[4] = '{1'b1, 16'h1234, 8'b1000_0000, 1'b0, 1, 2, 2, 16'h1234, 16'h1234, 7};
        vt[5] = '{1'b0, 16'h7FFE, 8'b1111_1111, 1'b1, 8, 10, 10, 16'h7FFE, 16'h8005, 7};

        for (int i = 0; i < 6; i++) begin
            run_op(vt[i].is_store, vt[i].base, vt[i].list, vt[i].hold_first ? 1 : 0, 1'(i % 2),
                   n_x, d_cyc, b_cyc, a_first, a_last, i_last);
            check("vec_xfers", 32'(n_x), 32'(vt[i].xfers));
            check("vec_done_cyc", 32'(d_cyc), 32'(vt[i].done_cyc));
            check("vec_busy_cyc", 32'(b_cyc), 32'(vt[i].busy_cyc));
            if (vt[i].xfers > 0) begin
                check("vec_first_addr", 32'(a_first), 32'(vt[i].first_addr));
                check("vec_last_addr",  32'(a_last), 32'(vt[i].last_addr));
                check("vec_last_idx",   32'(i_last), 32'(vt[i].last_idx));
            end
        end

        // Reset in the middle of a full-list store.
        @(negedge clk);
        bus.start = 1'b1; bus.is_store = 1'b1; bus.base_addr = 16'h0100; bus.reg_list = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        check("midxfer_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        idle_outputs("rst_xfer");
        check("rst_xfer_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_xfer_idx",  32'(bus.reg_idx), 32'd0);
        dn_seen = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (bus.done || bus.busy || !bus.mem_write_n) dn_seen++;
        end
        check("rst_xfer_quiet", 32'(dn_seen), 32'd0);

        // Reset coinciding with start in IDLE.
        @(negedge clk);
        reset = 1'b1; bus.start = 1'b1; bus.is_store = 1'b0; bus.base_addr = 16'h4444; bus.reg_list = 8'h3C;
        #1;
        check("rst_start_stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        #1;
        idle_outputs("rst_start");
        check("rst_start_addr", 32'(bus.mem_addr), 32'd0);
        dn_seen = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (bus.done || bus.busy || bus.rf_we) dn_seen++;
        end
        check("rst_start_quiet", 32'(dn_seen), 32'd0);

        // Randomized operations against the queue model.
        for (int t = 0; t < 24; t++) begin
            st = 1'($urandom);
            base = ($urandom_range(3) == 0) ? 16'hFFF8 + 16'($urandom_range(7)) : 16'($urandom);
            r = $urandom_range(9);
            list = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            run_op(st, base, list, 2, 1'($urandom), n_x, d_cyc, b_cyc, a_first, a_last, i_last);
            check("rand_xfers", 32'(n_x), 32'($countones(list)));
            check("rand_busy_cyc", 32'(b_cyc), 32'(d_cyc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
